// File: rtl/instruction_encoder_loader_if.sv
// Request and program-memory write bundle for instruction_encoder_loader.
// slave = loader view, master = host/memory-model view.
interface instruction_encoder_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic [2:0]        in_alu_op;
    logic [2:0]        in_reg;
    logic [7:0]        in_imm;
    logic [9:0]        in_mem_addr;
    logic [4:0]        in_target;
    logic              in_last;

    logic              prog_wr_en;
    logic              prog_wr_ready;
    logic [ADDR_W-1:0] prog_addr;
    logic [15:0]       prog_wr_data;

    modport slave (
        input  in_valid, in_kind, in_alu_op, in_reg, in_imm, in_mem_addr,
               in_target, in_last, prog_wr_ready,
        output in_ready, prog_wr_en, prog_addr, prog_wr_data
    );

    modport master (
        output in_valid, in_kind, in_alu_op, in_reg, in_imm, in_mem_addr,
               in_target, in_last, prog_wr_ready,
        input  in_ready, prog_wr_en, prog_addr, prog_wr_data
    );
endinterface

// File: rtl/instruction_encoder_loader.sv
// Encodes symbolic instruction requests and streams them into program memory.
// Optional LOADER_CHECKSUM_EN adds a running 16-bit sum of written words.

// Generic synchronous FIFO with flush.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: caller must not push when full or pop when empty; such requests are ignored.
module instruction_encoder_loader_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// Instruction encoder and program loader.
// Latency: accepted request is presented to program memory one cycle later at the earliest.
// Backpressure: in_ready drops when the FIFO is full or outside LOADING; writes stall on prog_wr_ready.
module instruction_encoder_loader #(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          base_addr,
    instruction_encoder_loader_if.slave bus,
    output logic                       busy,
    output logic                       done,
    output logic                       err_illegal,
    output logic                       err_overflow,
`ifdef LOADER_CHECKSUM_EN
    output logic [15:0]                checksum,
`endif
    output logic [ADDR_W:0]            words_written
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOADING = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;
    localparam logic [1:0] ST_ERROR   = 2'd3;

    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       enc_word;
    logic [16:0]       head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              loading;
    logic              accept;
    logic              illegal;
    logic              push;
    logic              write;

    always_comb begin
        enc_word = '0;
        case (bus.in_kind)
            3'd0:    enc_word = {1'b0, bus.in_alu_op, 9'b0, bus.in_reg};
            3'd1:    enc_word = {1'b0, bus.in_alu_op, 3'b0, 1'b1, bus.in_imm};
            3'd2:    enc_word = {8'h70, 3'b0, bus.in_target};
            3'd3:    enc_word = 16'h6000;
            3'd4:    enc_word = {8'hC0, 5'b0, bus.in_reg};
            3'd5:    enc_word = {8'hC1, bus.in_imm};
            3'd6:    enc_word = {6'b111000, bus.in_mem_addr};
            3'd7:    enc_word = {6'b101000, bus.in_mem_addr};
            default: enc_word = '0;
        endcase
    end

    // ALU opcodes 110/111 have no decoder meaning; they are swallowed and flagged.
    assign illegal = (bus.in_kind[2:1] == 2'b00) && (bus.in_alu_op[2:1] == 2'b11);

    assign loading      = (state == ST_LOADING);
    assign bus.in_ready = loading && !fifo_full;
    assign accept       = bus.in_valid && bus.in_ready && !start;
    assign push         = accept && !illegal;

    assign bus.prog_wr_en   = loading && !fifo_empty;
    assign bus.prog_wr_data = bus.prog_wr_en ? head[15:0] : 16'h0000;
    assign bus.prog_addr    = addr;
    assign write            = bus.prog_wr_en && bus.prog_wr_ready && !start;
    assign busy             = loading;

    instruction_encoder_loader_fifo #(
        .WIDTH (17),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (start),
        .push     (push),
        .push_dat ({bus.in_last, enc_word}),
        .pop      (write),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            addr          <= '0;
            done          <= 1'b0;
            err_illegal   <= 1'b0;
            err_overflow  <= 1'b0;
            words_written <= '0;
        end else if (start) begin
            state         <= ST_LOADING;
            addr          <= base_addr;
            done          <= 1'b0;
            err_illegal   <= 1'b0;
            err_overflow  <= 1'b0;
            words_written <= '0;
        end else begin
            if (write) begin
                words_written <= words_written + 1'b1;
                if (head[16]) begin
                    done  <= 1'b1;
                    state <= ST_DONE;
                end else begin
                    addr <= addr + 1'b1;
                    if (addr == ADDR_MAX) begin
                        err_overflow <= 1'b1;
                        state        <= ST_ERROR;
                    end
                end
            end
            // An illegal request overrides any same-cycle completion.
            if (accept && illegal) begin
                err_illegal <= 1'b1;
                state       <= ST_ERROR;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (start) begin
            checksum <= '0;
        end else if (write) begin
            checksum <= checksum + bus.prog_wr_data;
        end
    end
`endif
endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Self-checking bench: vector table, directed corner sequences, randomized loads vs reference model.
module tb_instruction_encoder_loader;
    localparam int ADDR_W = 10;

    typedef struct {
        logic [2:0]  kind;
        logic [2:0]  op;
        logic [2:0]  rg;
        logic [7:0]  imm;
        logic [9:0]  mem;
        logic [4:0]  tgt;
        logic [15:0] exp;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              busy, done, err_illegal, err_overflow;
    logic [ADDR_W:0]   words_written;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0]       checksum;
`endif

    instruction_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instruction_encoder_loader #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .base_addr     (base_addr),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .err_illegal   (err_illegal),
        .err_overflow  (err_overflow),
`ifdef LOADER_CHECKSUM_EN
        .checksum      (checksum),
`endif
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit rand_ready = 1'b0;

    logic [ADDR_W-1:0] cap_addr [$];
    logic [15:0]       cap_data [$];

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.prog_wr_en === 1'b1 && bus.prog_wr_ready === 1'b1 && start === 1'b0) begin
            cap_addr.push_back(bus.prog_addr);
            cap_data.push_back(bus.prog_wr_data);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) bus.prog_wr_ready = 1'($urandom_range(0, 1));
    end

    // Reference encoding built from the field positions as plain arithmetic.
    function automatic logic [15:0] model_word(vec_t v);
        int w;
        case (v.kind)
            3'd0:    w = int'(v.op) * 4096 + int'(v.rg);
            3'd1:    w = int'(v.op) * 4096 + 256 + int'(v.imm);
            3'd2:    w = 'h7000 + int'(v.tgt);
            3'd3:    w = 'h6000;
            3'd4:    w = 'hC000 + int'(v.rg);
            3'd5:    w = 'hC100 + int'(v.imm);
            3'd6:    w = 'hE000 + int'(v.mem);
            default: w = 'hA000 + int'(v.mem);
        endcase
        return w[15:0];
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(logic [ADDR_W-1:0] b);
        start     = 1'b1;
        base_addr = b;
        @(posedge clk); #1;
        start = 1'b0;
        cap_addr.delete();
        cap_data.delete();
    endtask

    task automatic send(vec_t v, logic last, int budget, output bit ok);
        bus.in_kind     = v.kind;
        bus.in_alu_op   = v.op;
        bus.in_reg      = v.rg;
        bus.in_imm      = v.imm;
        bus.in_mem_addr = v.mem;
        bus.in_target   = v.tgt;
        bus.in_last     = last;
        bus.in_valid    = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) ok = 1'b1;
            @(posedge clk); #1;
            if (ok) break;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_finish(string name, int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1 || err_illegal === 1'b1 || err_overflow === 1'b1) hit = 1'b1;
            @(posedge clk); #1;
            if (hit) break;
        end
        check({name, "_timeout"}, 32'(hit), 32'd1);
    endtask

    task automatic check_writes(string name, logic [ADDR_W-1:0] base, logic [15:0] exp [$]);
        int n;
        check({name, "_count"}, 32'(cap_data.size()), 32'(exp.size()));
        n = (cap_data.size() < exp.size()) ? cap_data.size() : exp.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", name, i), 32'(cap_addr[i]), 32'((int'(base) + i) % 1024));
            check($sformatf("%s_data%0d", name, i), 32'(cap_data[i]), 32'(exp[i]));
        end
    endtask

    vec_t        tbl [11];
    vec_t        v;
    vec_t        reqs [$];
    logic [15:0] exp_q [$];
    bit          ok;

    initial begin
        tbl[0]  = '{3'd0, 3'd2, 3'd5, 8'hA3, 10'h2C7, 5'h13, 16'h2005};
        tbl[1]  = '{3'd1, 3'd2, 3'd5, 8'hA3, 10'h2C7, 5'h13, 16'h21A3};
        tbl[2]  = '{3'd2, 3'd2, 3'd5, 8'hA3, 10'h2C7, 5'h13, 16'h7013};
        tbl[3]  = '{3'd3, 3'd2, 3'd5, 8'hA3, 10'h2C7, 5'h13, 16'h6000};
        tbl[4]  = '{3'd4, 3'd2, 3'd5, 8'hA3, 10'h2C7, 5'h13, 16'hC005};
        tbl[5]  = '{3'd5, 3'd2, 3'd5, 8'hA3, 10'h2C7, 5'h13, 16'hC1A3};
        tbl[6]  = '{3'd6, 3'd2, 3'd5, 8'hA3, 10'h2C7, 5'h13, 16'hE2C7};
        tbl[7]  = '{3'd7, 3'd2, 3'd5, 8'hA3, 10'h2C7, 5'h13, 16'hA2C7};
        tbl[8]  = '{3'd0, 3'd0, 3'd7, 8'h00, 10'h000, 5'h00, 16'h0007};
        tbl[9]  = '{3'd1, 3'd5, 3'd0, 8'hFF, 10'h000, 5'h1F, 16'h51FF};
        tbl[10] = '{3'd6, 3'd0, 3'd0, 8'h00, 10'h3FF, 5'h1F, 16'hE3FF};

        rst_n = 1'b0; start = 1'b0; base_addr = '0;
        bus.in_valid = 1'b0; bus.in_kind = '0; bus.in_alu_op = '0; bus.in_reg = '0;
        bus.in_imm = '0; bus.in_mem_addr = '0; bus.in_target = '0; bus.in_last = 1'b0;
        bus.prog_wr_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_errs", 32'({err_illegal, err_overflow}), 0);
        check("rst_words", 32'(words_written), 0);
        check("rst_addr", 32'(bus.prog_addr), 0);
        check("rst_wr_en", 32'(bus.prog_wr_en), 0);
        check("rst_in_ready", 32'(bus.in_ready), 0);
        rst_n = 1'b1;
        wait_cycles(1);

        // Single ALU_IMM word.
        bus.prog_wr_ready = 1'b1;
        do_start(10'h010);
        v = '{3'd1, 3'd1, 3'd0, 8'h5A, 10'h000, 5'h00, 16'h115A};
        send(v, 1'b1, 50, ok);
        wait_finish("single", 50);
        exp_q = '{16'h115A};
        check_writes("single", 10'h010, exp_q);
        check("single_done", 32'(done), 1);
        check("single_words", 32'(words_written), 1);
        check("single_busy", 32'(busy), 0);

        // Vector table: every kind plus field extremes at consecutive addresses.
        do_start(10'h100);
        exp_q.delete();
        for (int i = 0; i < 11; i++) begin
            send(tbl[i], 1'(i == 10), 50, ok);
            exp_q.push_back(tbl[i].exp);
        end
        wait_finish("table", 100);
        check_writes("table", 10'h100, exp_q);
        check("table_words", 32'(words_written), 11);
`ifdef LOADER_CHECKSUM_EN
        begin
            logic [15:0] sum = '0;
            foreach (exp_q[i]) sum = sum + exp_q[i];
            check("table_checksum", 32'(checksum), 32'(sum));
        end
`endif

        // Memory stalled while the FIFO fills.
        bus.prog_wr_ready = 1'b0;
        do_start(10'h040);
        for (int i = 0; i < 4; i++) send(tbl[i], 1'b0, 20, ok);
        check("bp_in_ready_low", 32'(bus.in_ready), 0);
        send(tbl[4], 1'b0, 3, ok);
        check("bp_fifth_refused", 32'(ok), 0);
        check("bp_wr_en", 32'(bus.prog_wr_en), 1);
        check("bp_data_hold", 32'(bus.prog_wr_data), 32'(tbl[0].exp));
        check("bp_addr_hold", 32'(bus.prog_addr), 32'h040);
        wait_cycles(3);
        check("bp_data_hold2", 32'(bus.prog_wr_data), 32'(tbl[0].exp));
        check("bp_addr_hold2", 32'(bus.prog_addr), 32'h040);
        check("bp_no_writes", 32'(cap_data.size()), 0);
        bus.prog_wr_ready = 1'b1;
        send(tbl[4], 1'b0, 20, ok);
        send(tbl[5], 1'b1, 20, ok);
        wait_finish("bp", 50);
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(tbl[i].exp);
        check_writes("bp", 10'h040, exp_q);

        // Illegal ALU opcode, then recovery via start.
        do_start(10'h080);
        v = '{3'd0, 3'd7, 3'd1, 8'h00, 10'h000, 5'h00, 16'h0000};
        send(v, 1'b1, 20, ok);
        wait_cycles(3);
        check("ill_flag", 32'(err_illegal), 1);
        check("ill_busy", 32'(busy), 0);
        check("ill_in_ready", 32'(bus.in_ready), 0);
        check("ill_no_write", 32'(cap_data.size()), 0);
        do_start(10'h090);
        check("ill_cleared", 32'(err_illegal), 0);
        check("ill_resume_busy", 32'(busy), 1);
        send(tbl[3], 1'b1, 20, ok);
        wait_finish("ill_resume", 50);
        exp_q = '{16'h6000};
        check_writes("ill_resume", 10'h090, exp_q);

        // Address wrap before the last word.
        do_start(10'h3FE);
        send(tbl[3], 1'b0, 20, ok);
        send(tbl[2], 1'b0, 20, ok);
        send(tbl[4], 1'b1, 20, ok);
        wait_finish("ovf", 50);
        wait_cycles(3);
        exp_q = '{16'h6000, 16'h7013};
        check_writes("ovf", 10'h3FE, exp_q);
        check("ovf_flag", 32'(err_overflow), 1);
        check("ovf_done", 32'(done), 0);
        check("ovf_words", 32'(words_written), 2);

        // Restart with words queued.
        bus.prog_wr_ready = 1'b0;
        do_start(10'h200);
        for (int i = 0; i < 3; i++) send(tbl[i], 1'b0, 20, ok);
        do_start(10'h300);
        check("rs_addr", 32'(bus.prog_addr), 32'h300);
        check("rs_flushed", 32'(bus.prog_wr_en), 0);
        check("rs_words", 32'(words_written), 0);
        bus.prog_wr_ready = 1'b1;
        wait_cycles(4);
        check("rs_no_old", 32'(cap_data.size()), 0);
        send(tbl[3], 1'b1, 20, ok);
        wait_finish("rs", 50);
        exp_q = '{16'h6000};
        check_writes("rs", 10'h300, exp_q);

        // Randomized loads with random memory backpressure.
        rand_ready = 1'b1;
        for (int it = 0; it < 25; it++) begin
            int n;
            logic [ADDR_W-1:0] b;
            n = $urandom_range(1, 10);
            b = ADDR_W'($urandom_range(0, 1023 - n));
            reqs.delete();
            exp_q.delete();
            for (int i = 0; i < n; i++) begin
                v.kind = 3'($urandom_range(0, 7));
                v.op   = 3'($urandom_range(0, 5));
                v.rg   = 3'($urandom);
                v.imm  = 8'($urandom);
                v.mem  = 10'($urandom);
                v.tgt  = 5'($urandom);
                v.exp  = model_word(v);
                reqs.push_back(v);
                exp_q.push_back(v.exp);
            end
            do_start(b);
            for (int i = 0; i < n; i++) begin
                send(reqs[i], 1'(i == n - 1), 200, ok);
                check($sformatf("rnd%0d_accept%0d", it, i), 32'(ok), 1);
            end
            wait_finish($sformatf("rnd%0d", it), 400);
            check_writes($sformatf("rnd%0d", it), b, exp_q);
            check($sformatf("rnd%0d_words", it), 32'(words_written), 32'(n));
            check($sformatf("rnd%0d_done", it), 32'(done), 1);
        end
        rand_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instruction_encoder_loader.md
Name: instruction_encoder_loader

Overview:
Writer-side counterpart of the instruction decoder. It accepts symbolic instruction requests over a valid/ready handshake and encodes each one into the 16-bit instruction word format the decoder consumes. Encoded words are buffered in a small FIFO and written sequentially into program memory, starting at a base address.
The block sits between a host/debug front-end and the program memory write port. It is used to load programs before the core runs.

Parameters:
ADDR_W, 10, program memory address width; wrap point is 2^ADDR_W-1
FIFO_DEPTH, 4, encoded-word FIFO entries; power of two, >=2

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: flush FIFO, load base address, enter LOADING
base_addr  in  ADDR_W  first program address, sampled on start
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid&&in_ready
in_kind  in  3  instruction class (see Behaviour)
in_alu_op  in  3  ALU opcode for ALU_REG/ALU_IMM
in_reg  in  3  register index
in_imm  in  8  immediate data
in_mem_addr  in  10  data memory address
in_target  in  5  jump/counter target
in_last  in  1  marks final instruction of program
prog_wr_en  out  1  write request to program memory
prog_wr_ready  in  1  memory accepts write this cycle
prog_addr  out  ADDR_W  write address
prog_wr_data  out  16  encoded instruction word
busy  out  1  state==LOADING
done  out  1  sticky; last word written
err_illegal  out  1  sticky; illegal ALU opcode requested
err_overflow  out  1  sticky; address wrapped before last word
words_written  out  ADDR_W+1  count of words written since start

Behaviour:
- Reset: state IDLE, FIFO empty, all outputs 0, prog_addr 0, words_written 0.
- States: IDLE, LOADING, DONE, ERROR. start from any state goes to LOADING. start clears the FIFO, done, errors and words_written, and sets prog_addr=base_addr. start has priority over same-cycle accept and write; both are discarded.
- in_ready = (state==LOADING) && !fifo_full.
- Encoding (kind: word), all unlisted bits 0:
  - 000 ALU_REG: [15]=0, [14:12]=alu_op, [8]=0, [2:0]=reg
  - 001 ALU_IMM: [15]=0, [14:12]=alu_op, [8]=1, [7:0]=imm
  - 010 JMP: 16'h7000 | target
  - 011 NOP: 16'h6000
  - 100 LD_REG: 16'hC000 | reg
  - 101 LD_IMM: 16'hC100 | imm
  - 110 ST_MEM: 16'hE000 | mem_addr
  - 111 LD_MEM: 16'hA000 | mem_addr
- Illegal request: ALU_REG/ALU_IMM with alu_op 110 or 111. The handshake still completes, but nothing is enqueued, err_illegal=1 and the next state is ERROR. In ERROR, in_ready=0 and prog_wr_en=0 until start.
- On accept, the encoded word and in_last are written into the FIFO at the clock edge. prog_wr_en is asserted the next cycle at the earliest.
- prog_wr_en = (state==LOADING) && !fifo_empty. prog_wr_data and prog_addr are driven from the FIFO head and the address register, and hold stable while prog_wr_ready=0.
- On each write (prog_wr_en && prog_wr_ready):
  - pop the FIFO, prog_addr += 1 (wraps mod 2^ADDR_W), words_written += 1.
  - If the popped entry is last: done=1, next state DONE, prog_addr is not incremented.
  - Else if prog_addr was 2^ADDR_W-1: err_overflow=1, next state ERROR.
- Requests after in_last are accepted only while in LOADING and the FIFO has room. Once DONE, in_ready=0.
- Simultaneous accept and write in the same cycle: FIFO count is unchanged, full/empty flags stay correct.

Optional Feature:
LOADER_CHECKSUM_EN: adds output checksum[15:0]. It is cleared on reset and start, and updated on every write as checksum <= checksum + prog_wr_data (mod 2^16). Without the macro the port does not exist and no adder is built.

Test Plan:
- Reset, then start with base_addr=10'h010, then ALU_IMM op=001 imm=8'h5A, last=1 -> one write at 0x010 with data 16'h115A. Then done=1, words_written=1, busy=0.
- Each of the 8 kinds (reg=5, imm=8'hA3, mem_addr=10'h2C7, target=5'h13, alu_op=010) -> words 16'h2005, 16'h21A3, 16'h7013, 16'h6000, 16'hC005, 16'hC1A3, 16'hE2C7, 16'hA2C7 at consecutive addresses.
- Hold prog_wr_ready=0 for 10 cycles while feeding 6 requests -> in_ready falls after FIFO_DEPTH accepts, prog_wr_data/prog_addr stay stable. Releasing ready writes all 6 words in order with no loss.
- ALU_REG alu_op=111 -> err_illegal=1, state ERROR, no write. A following start clears err_illegal and loading resumes.
- base_addr=10'h3FE, 3 requests, last on the third -> writes at 0x3FE and 0x3FF, then err_overflow=1 and the third word is not written.
- start asserted mid-load with 3 words queued -> FIFO flushed, no further writes of the old words, prog_addr=new base_addr.
